// File: rtl/palette_bank_lut.sv
//==============================================================================
// Module   : palette_bank_lut
// Purpose  : Shared, writable multi-bank sprite colour lookup. Maps a sprite
//            pixel index through a selectable bank to 12-bit RGB. It adds
//            frame-synchronous bank flashing and a global fade-to-black, and
//            flags index 0 as transparent. Two-stage pipeline: table read,
//            then fade subtraction.
// Ports    : Clk, Reset_n (sync, active-low)
//            frame_start              - one pulse per frame
//            pix_valid/index/bank_sel - lookup request
//            flash_en                 - enable bank flashing
//            fade_start/fade_clear    - fade control pulses
//            wr_en/wr_bank/wr_index/wr_rgb - table write port
//            red/green/blue/out_valid/out_transparent - lookup result
//            flash_phase, fade_done   - status
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module palette_bank_lut #(
  parameter int INDEX_W      = 2,
  parameter int NUM_BANKS    = 4,
  parameter int COLOR_W      = 4,
  parameter int FLASH_PERIOD = 16,
  parameter int FADE_FRAMES  = 4
) (
  input  logic                          Clk,
  input  logic                          Reset_n,
  input  logic                          frame_start,
  input  logic                          pix_valid,
  input  logic [INDEX_W-1:0]            index,
  input  logic [$clog2(NUM_BANKS)-1:0]  bank_sel,
  input  logic                          flash_en,
  input  logic                          fade_start,
  input  logic                          fade_clear,
  input  logic                          wr_en,
  input  logic [$clog2(NUM_BANKS)-1:0]  wr_bank,
  input  logic [INDEX_W-1:0]            wr_index,
  input  logic [3*COLOR_W-1:0]          wr_rgb,
  output logic [COLOR_W-1:0]            red,
  output logic [COLOR_W-1:0]            green,
  output logic [COLOR_W-1:0]            blue,
  output logic                          out_valid,
  output logic                          out_transparent,
  output logic                          flash_phase,
  output logic                          fade_done
);

  localparam int BW      = $clog2(NUM_BANKS);
  localparam int ENTRIES = 2**INDEX_W;
  localparam int RGB_W   = 3*COLOR_W;
  localparam int FLW     = $clog2(FLASH_PERIOD+1);
  localparam int FFW     = $clog2(FADE_FRAMES+1);

  localparam logic [FLW-1:0]     FLASH_LAST = FLW'(FLASH_PERIOD-1);
  localparam logic [FFW-1:0]     FADE_LAST  = FFW'(FADE_FRAMES-1);
  // Level one step short of full black; stepping past it enters BLACK.
  localparam logic [COLOR_W-1:0] LEVEL_PRE  = COLOR_W'(2**COLOR_W-2);

  // ---------------------------------------------------------------------------
  // Colour table
  // ---------------------------------------------------------------------------
  logic [RGB_W-1:0] lut [NUM_BANKS][ENTRIES];

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        for (int e = 0; e < ENTRIES; e++) begin
          lut[b][e] <= '0;
        end
      end
    end else if (wr_en) begin
      lut[wr_bank][wr_index] <= wr_rgb;
    end
  end

  // ---------------------------------------------------------------------------
  // Flash phase: toggles every FLASH_PERIOD frames while enabled
  // ---------------------------------------------------------------------------
  logic [FLW-1:0] flash_cnt;

  always_ff @(posedge Clk) begin
    if (!Reset_n || !flash_en) begin
      flash_cnt   <= '0;
      flash_phase <= 1'b0;
    end else if (frame_start) begin
      if (flash_cnt == FLASH_LAST) begin
        flash_cnt   <= '0;
        flash_phase <= ~flash_phase;
      end else begin
        flash_cnt <= flash_cnt + FLW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Fade FSM
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    FADE_IDLE  = 2'd0,
    FADE_RUN   = 2'd1,
    FADE_BLACK = 2'd2
  } fade_state_t;

  fade_state_t        state_q, state_d;
  logic [COLOR_W-1:0] level_q, level_d;
  logic [FFW-1:0]     fcnt_q,  fcnt_d;

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q <= FADE_IDLE;
      level_q <= '0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      fcnt_q  <= fcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    fcnt_d  = fcnt_q;
    if (fade_clear) begin
      state_d = FADE_IDLE;
      level_d = '0;
      fcnt_d  = '0;
    end else begin
      case (state_q)
        FADE_IDLE: begin
          // A frame_start coinciding with fade_start is deliberately not counted.
          if (fade_start) begin
            state_d = FADE_RUN;
            level_d = '0;
            fcnt_d  = '0;
          end
        end
        FADE_RUN: begin
          if (frame_start) begin
            if (fcnt_q == FADE_LAST) begin
              fcnt_d  = '0;
              level_d = level_q + COLOR_W'(1);
              if (level_q == LEVEL_PRE) begin
                state_d = FADE_BLACK;
              end
            end else begin
              fcnt_d = fcnt_q + FFW'(1);
            end
          end
        end
        FADE_BLACK: begin
          state_d = FADE_BLACK;
        end
        default: begin
          state_d = FADE_IDLE;
          level_d = '0;
          fcnt_d  = '0;
        end
      endcase
    end
  end

  assign fade_done = (state_q == FADE_BLACK);

  // ---------------------------------------------------------------------------
  // Stage 1: table read through the flash-adjusted bank
  // ---------------------------------------------------------------------------
  logic [BW-1:0]    eff_bank;
  logic             s1_valid;
  logic             s1_transp;
  logic [RGB_W-1:0] s1_rgb;

  // Phase 1 swaps to the bank's LSB partner (2k <-> 2k+1).
  assign eff_bank = bank_sel ^ BW'(flash_phase);

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      s1_valid  <= 1'b0;
      s1_transp <= 1'b0;
      s1_rgb    <= '0;
    end else begin
      s1_valid  <= pix_valid;
      s1_transp <= (index == '0);
      s1_rgb    <= lut[eff_bank][index];
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: saturating fade subtraction; colour holds when no valid data
  // ---------------------------------------------------------------------------
  function automatic logic [COLOR_W-1:0] fade_ch(input logic [COLOR_W-1:0] c,
                                                 input logic [COLOR_W-1:0] l);
    return (c > l) ? (c - l) : '0;
  endfunction

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      out_valid       <= 1'b0;
      out_transparent <= 1'b0;
      red             <= '0;
      green           <= '0;
      blue            <= '0;
    end else begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        red             <= fade_ch(s1_rgb[RGB_W-1 -: COLOR_W], level_q);
        green           <= fade_ch(s1_rgb[2*COLOR_W-1 -: COLOR_W], level_q);
        blue            <= fade_ch(s1_rgb[COLOR_W-1:0], level_q);
        out_transparent <= s1_transp;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_palette_bank_lut.sv
//==============================================================================
// Module   : tb_palette_bank_lut
// Purpose  : Self-checking bench for palette_bank_lut, with directed steps
//            followed by a randomized run against a behavioural model.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_palette_bank_lut;

  localparam int FP = 2;
  localparam int FF = 1;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        frame_start, pix_valid, flash_en, fade_start, fade_clear, wr_en;
  logic [1:0]  index, bank_sel, wr_bank, wr_index;
  logic [11:0] wr_rgb;
  logic [3:0]  red, green, blue;
  logic        out_valid, out_transparent, flash_phase, fade_done;

  palette_bank_lut #(
    .INDEX_W(2), .NUM_BANKS(4), .COLOR_W(4), .FLASH_PERIOD(FP), .FADE_FRAMES(FF)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_start(frame_start), .pix_valid(pix_valid),
    .index(index), .bank_sel(bank_sel), .flash_en(flash_en), .fade_start(fade_start),
    .fade_clear(fade_clear), .wr_en(wr_en), .wr_bank(wr_bank), .wr_index(wr_index),
    .wr_rgb(wr_rgb), .red(red), .green(green), .blue(blue), .out_valid(out_valid),
    .out_transparent(out_transparent), .flash_phase(flash_phase), .fade_done(fade_done)
  );

  always #5 Clk = ~Clk;

  int vectors = 0;
  int errors  = 0;

  // Reference model state
  logic [11:0] m_mem [4][4];
  int          m_phase, m_fcnt, m_level, m_frames;
  bit          m_fading, m_black;
  bit          s1_v, s1_t, e_v, e_t;
  logic [11:0] s1_rgb, e_rgb;

  function automatic int sat(input int c, input int l);
    return (c > l) ? c - l : 0;
  endfunction

  task automatic model_reset();
    for (int b = 0; b < 4; b++)
      for (int e = 0; e < 4; e++) m_mem[b][e] = 12'h000;
    m_phase = 0; m_fcnt = 0; m_level = 0; m_frames = 0;
    m_fading = 0; m_black = 0;
    s1_v = 0; s1_t = 0; s1_rgb = 0; e_v = 0; e_t = 0; e_rgb = 0;
  endtask

  // Everything the DUT does at one rising edge, from pre-edge inputs and state.
  task automatic model_edge();
    if (!Reset_n) begin
      model_reset();
      return;
    end
    e_v = s1_v;
    if (s1_v) begin
      e_rgb = {4'(sat(int'(s1_rgb[11:8]), m_level)),
               4'(sat(int'(s1_rgb[7:4]),  m_level)),
               4'(sat(int'(s1_rgb[3:0]),  m_level))};
      e_t = s1_t;
    end
    s1_v   = pix_valid;
    s1_t   = (index == 2'd0);
    s1_rgb = m_mem[int'(bank_sel) ^ m_phase][index];
    if (wr_en) m_mem[wr_bank][wr_index] = wr_rgb;
    if (!flash_en) begin
      m_phase = 0; m_fcnt = 0;
    end else if (frame_start) begin
      m_fcnt++;
      if (m_fcnt == FP) begin m_fcnt = 0; m_phase = 1 - m_phase; end
    end
    if (fade_clear) begin
      m_fading = 0; m_black = 0; m_level = 0; m_frames = 0;
    end else if (!m_fading && !m_black) begin
      if (fade_start) begin m_fading = 1; m_frames = 0; end
    end else if (m_fading && frame_start) begin
      m_frames++;
      if (m_frames == FF) begin
        m_frames = 0;
        m_level++;
        if (m_level == 15) begin m_fading = 0; m_black = 1; end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    model_edge();
    #1;
    chk("out_valid", 32'(out_valid), 32'(e_v));
    chk("rgb", 32'({red, green, blue}), 32'(e_rgb));
    if (e_v) chk("transparent", 32'(out_transparent), 32'(e_t));
    chk("flash_phase", 32'(flash_phase), 32'(m_phase));
    chk("fade_done", 32'(fade_done), 32'(m_black));
  endtask

  initial begin
    model_reset();
    Reset_n = 0; frame_start = 0; pix_valid = 0; flash_en = 0; fade_start = 0;
    fade_clear = 0; wr_en = 0; index = 0; bank_sel = 0; wr_bank = 0;
    wr_index = 0; wr_rgb = 0;
    tick(); tick();
    chk("reset_all_out", 32'({red, green, blue, out_valid, out_transparent,
                              flash_phase, fade_done}), 32'd0);
    Reset_n = 1;
    tick();

    // Program and read back
    wr_en = 1; wr_bank = 1; wr_index = 2; wr_rgb = 12'hFA2; tick();
    wr_en = 0; pix_valid = 1; bank_sel = 1; index = 2; tick();
    index = 0; tick();
    chk("prog_rgb", 32'({red, green, blue}), 32'h0FA2);
    chk("prog_valid", 32'(out_valid), 32'd1);
    pix_valid = 0; tick();
    chk("idx0_transparent", 32'(out_transparent), 32'd1);
    tick();
    chk("idle_valid", 32'(out_valid), 32'd0);

    // Write/read collision returns the old value
    wr_en = 1; wr_bank = 0; wr_index = 1; wr_rgb = 12'hFF0;
    pix_valid = 1; bank_sel = 0; index = 1; tick();
    wr_en = 0; tick();
    chk("collide_old", 32'({red, green, blue}), 32'h000);
    pix_valid = 0; tick();
    chk("collide_new", 32'({red, green, blue}), 32'hFF0);

    // Flashing between banks 2 and 3
    wr_en = 1; wr_bank = 2; wr_index = 1; wr_rgb = 12'h00E; tick();
    wr_bank = 3; wr_rgb = 12'hFFF; tick();
    wr_en = 0; flash_en = 1; pix_valid = 1; bank_sel = 2; index = 1;
    for (int i = 0; i < 24; i++) begin
      frame_start = (i % 3 == 0);
      tick();
    end
    frame_start = 0; flash_en = 0;
    tick(); tick(); tick();
    chk("flash_off_rgb", 32'({red, green, blue}), 32'h00E);
    chk("flash_off_phase", 32'(flash_phase), 32'd0);

    // Fade to black
    wr_en = 1; wr_bank = 0; wr_index = 3; wr_rgb = 12'hF72; tick();
    wr_en = 0; bank_sel = 0; index = 3; pix_valid = 1; tick();
    fade_start = 1; tick();
    fade_start = 0;
    for (int k = 1; k <= 15; k++) begin
      frame_start = 1; tick();
      frame_start = 0; tick();
      if (k == 2) chk("fade_l2", 32'({red, green, blue}), 32'hD50);
      if (k == 7) chk("fade_l7", 32'({red, green, blue}), 32'h800);
    end
    chk("fade_done15", 32'(fade_done), 32'd1);
    chk("fade_black_rgb", 32'({red, green, blue}), 32'h000);

    // Priority: clear beats start; frame with start in IDLE not counted
    fade_clear = 1; tick();
    fade_clear = 0; fade_start = 1; tick();
    fade_start = 0;
    for (int k = 0; k < 3; k++) begin frame_start = 1; tick(); frame_start = 0; tick(); end
    fade_clear = 1; fade_start = 1; tick();
    fade_clear = 0; fade_start = 0; tick();
    chk("prio_clear_rgb", 32'({red, green, blue}), 32'hF72);
    fade_start = 1; frame_start = 1; tick();
    fade_start = 0; frame_start = 0; tick();
    chk("start_frame_uncounted", 32'({red, green, blue}), 32'hF72);

    // Randomized run
    for (int i = 0; i < 3000; i++) begin
      Reset_n     = ($urandom_range(0, 299) != 0);
      frame_start = ($urandom_range(0, 3) == 0);
      pix_valid   = ($urandom_range(0, 3) != 0);
      index       = 2'($urandom_range(0, 3));
      bank_sel    = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 49) == 0) flash_en = ~flash_en;
      fade_start  = ($urandom_range(0, 39) == 0);
      fade_clear  = ($urandom_range(0, 119) == 0);
      wr_en       = ($urandom_range(0, 2) == 0);
      wr_bank     = 2'($urandom_range(0, 3));
      wr_index    = 2'($urandom_range(0, 3));
      wr_rgb      = 12'($urandom);
      tick();
    end

    // Mid-operation reset during fade with flashing active
    Reset_n = 1; wr_en = 0; fade_start = 0; fade_clear = 1; frame_start = 0;
    pix_valid = 1; bank_sel = 0; index = 3; tick();
    fade_clear = 0; fade_start = 1; flash_en = 1; tick();
    fade_start = 0;
    for (int k = 0; k < 3; k++) begin frame_start = 1; tick(); frame_start = 0; tick(); end
    Reset_n = 0; tick();
    chk("midreset_out", 32'({red, green, blue, out_valid, out_transparent,
                             flash_phase, fade_done}), 32'd0);
    Reset_n = 1; flash_en = 0; bank_sel = 1; index = 2; tick();
    bank_sel = 0; index = 3; tick();
    chk("post_reset_rd1", 32'({red, green, blue, out_valid}), 32'h0001);
    pix_valid = 0; tick();
    chk("post_reset_rd2", 32'({red, green, blue, out_valid}), 32'h0001);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/palette_bank_lut.md
# palette_bank_lut

Programmable, multi-bank sprite colour lookup that replaces the per-sprite fixed palettes with one shared, writable table. It maps a sprite pixel index to a 12-bit RGB value through one of several banks, adds frame-synchronous bank flashing for frightened ghosts and a global fade-to-black for death and level transitions, and flags index 0 as transparent. It sits between the sprite ROM readout and the VGA colour mux in the draw pipeline.

## Interface
Parameters:
- INDEX_W, default 2: pixel index width; each bank holds 2^INDEX_W entries.
- NUM_BANKS, default 4: number of banks; power of two, at least 2.
- COLOR_W, default 4: bits per colour channel.
- FLASH_PERIOD, default 16: frame_start pulses per flash half-period; at least 1.
- FADE_FRAMES, default 4: frame_start pulses per fade step; at least 1.

Ports (BW = log2(NUM_BANKS)):
- Clk  in  1  system clock. One clock; reset is synchronous and active-low.
- Reset_n  in  1  synchronous, active-low reset.
- frame_start  in  1  one-cycle pulse per frame (vsync edge).
- pix_valid  in  1  index/bank_sel valid this cycle.
- index  in  INDEX_W  sprite pixel index.
- bank_sel  in  BW  requested bank.
- flash_en  in  1  enable bank flashing.
- fade_start  in  1  pulse: begin fade-out.
- fade_clear  in  1  pulse: cancel fade, restore full brightness.
- wr_en  in  1  table write strobe.
- wr_bank  in  BW  write bank.
- wr_index  in  INDEX_W  write entry.
- wr_rgb  in  3*COLOR_W  write data, {r,g,b}.
- red, green, blue  out  COLOR_W each  looked-up, faded colour.
- out_valid  out  1  red/green/blue/out_transparent valid.
- out_transparent  out  1  source index was 0.
- flash_phase  out  1  current flash phase.
- fade_done  out  1  fade has reached full black.

## Operation
- Table: NUM_BANKS × 2^INDEX_W entries of 3*COLOR_W bits in flops. Reset clears every entry to 0.
- Write: when wr_en=1, entry [wr_bank][wr_index] takes wr_rgb at the clock edge. A read of the same entry in the same cycle returns the old value.
- Effective bank: bank_sel XOR {BW-1 zeros, flash_phase}. Phase 1 selects the bank's LSB-partner, so the frightened blue/white pair lives in banks 2k and 2k+1.
- Flash counter: while flash_en=1, each frame_start increments the counter. On reaching FLASH_PERIOD, the counter clears and flash_phase toggles. When flash_en=0, the counter and flash_phase clear on the next edge.
- Fade FSM, with level L of COLOR_W bits and frame counter F:
  - IDLE: L=0. fade_start moves to FADING with F=0. A frame_start in that same cycle is not counted.
  - FADING: each frame_start increments F. On F reaching FADE_FRAMES, F clears and L increments. Reaching L = 2^COLOR_W-1 moves to BLACK. fade_start is ignored.
  - BLACK: L = max and fade_done=1. fade_start is ignored.
  - fade_clear in any state moves to IDLE with L=0, F=0. It has priority over fade_start in the same cycle.
- Channel arithmetic: out = (c > L) ? c - L : 0, per channel, unsigned and saturating, with no wrap-around.
- out_transparent = (index == 0), carried through the pipeline with pix_valid.

## Timing
- Latency is 2 cycles from pix_valid/index/bank_sel to out_valid and colour.
  - Stage 1 registers the table read plus the index==0 flag.
  - Stage 2 registers the fade subtraction.
- Fully pipelined: one lookup per cycle with no stalls. pix_valid=0 produces out_valid=0 two cycles later; colour holds its last value.
- Stage 1 samples the effective bank. A flash_phase toggle affects lookups issued from the cycle after the toggle.
- Stage 2 samples L. A level change affects outputs from stage 1 data in the cycle after the change.
- Reset (valid mid-operation) clears, at the edge:
  - outputs: red, green, blue, out_valid, out_transparent, flash_phase, fade_done all 0.
  - state: FSM to IDLE, all counters and pipeline registers 0.
  - table: every entry 0.

## Test plan
- Reset then program: write bank1[2]=12'hFA2, then issue pix_valid with bank_sel=1, index=2. Expect out_valid and RGB F,A,2 exactly 2 cycles later. index=0 gives out_transparent=1.
- Write/read collision: write bank0[1]=12'hFF0 while reading bank0[1] in the same cycle. Expect the old value 000. The read on the next cycle returns FF0.
- Flash: bank2[1]=00E, bank3[1]=FFF, flash_en=1, FLASH_PERIOD=2, continuous reads from bank 2. Expect output to alternate 00E/FFF every 2 frame_start pulses. Dropping flash_en returns output to 00E with flash_phase=0.
- Fade: entry F72, FADE_FRAMES=1, fade_start. After 2 frames expect D50; after 7 frames expect 800. fade_done asserts after 15 frame_start pulses with RGB 000.
- Priority: fade_clear and fade_start in the same cycle during FADING. Expect IDLE and L=0; a simultaneous frame_start in IDLE with fade_start is not counted.
- Mid-operation reset: assert Reset_n=0 during FADING with flash active. Expect all outputs 0 next edge. A subsequent read of any entry returns 000.
